// File: rtl/arith_pkg.sv
// Shared types for the bit-serial arithmetic blocks.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow-out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one full-subtractor cell walks the operands LSB first,
// producing a-b, unsigned borrow and signed overflow after WIDTH cycles.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_sh_reg, b_sh_reg, diff_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             bin_reg, a_msb_reg, b_msb_reg, borrow_reg, overflow_reg;
    logic             cell_d, cell_bout;
    logic             accept, last_bit;

    assign accept   = start && (state_reg == IDLE);
    assign last_bit = (state_reg == RUN) && (cnt_reg == CNT_W'(WIDTH - 1));

    full_subtractor u_cell (
        .a    (a_sh_reg[0]),
        .b    (b_sh_reg[0]),
        .bin  (bin_reg),
        .d    (cell_d),
        .bout (cell_bout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The minuend register doubles as the result register: difference bits
    // enter at the top as operand bits leave at the bottom.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_reg     <= '0;
            b_sh_reg     <= '0;
            cnt_reg      <= '0;
            bin_reg      <= 1'b0;
            a_msb_reg    <= 1'b0;
            b_msb_reg    <= 1'b0;
            diff_reg     <= '0;
            borrow_reg   <= 1'b0;
            overflow_reg <= 1'b0;
        end else if (accept) begin
            a_sh_reg  <= a;
            b_sh_reg  <= b;
            cnt_reg   <= '0;
            bin_reg   <= 1'b0;
            a_msb_reg <= a[WIDTH-1];
            b_msb_reg <= b[WIDTH-1];
        end else if (state_reg == RUN) begin
            a_sh_reg <= {cell_d, a_sh_reg[WIDTH-1:1]};
            b_sh_reg <= b_sh_reg >> 1;
            bin_reg  <= cell_bout;
            cnt_reg  <= cnt_reg + CNT_W'(1);
            if (last_bit) begin
                diff_reg     <= {cell_d, a_sh_reg[WIDTH-1:1]};
                borrow_reg   <= cell_bout;
                overflow_reg <= (a_msb_reg ^ b_msb_reg) & (cell_d ^ a_msb_reg);
            end
        end
    end

    assign ready    = (state_reg == IDLE);
    assign done     = (state_reg == DONE);
    assign diff     = diff_reg;
    assign borrow   = borrow_reg;
    assign overflow = overflow_reg;

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand and result bit width (legal range 2..32).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request to begin one subtraction; sampled only when ready=1.
REQ-005 SHALL have port a  input  WIDTH  minuend; captured on accepted start.
REQ-006 SHALL have port b  input  WIDTH  subtrahend; captured on accepted start.
REQ-007 SHALL have port ready  output  1  high only in IDLE; start accepted when start=1 and ready=1.
REQ-008 SHALL have port done  output  1  one-cycle pulse marking a valid new result.
REQ-009 SHALL have port diff  output  WIDTH  result a-b modulo 2^WIDTH.
REQ-010 SHALL have port borrow  output  1  unsigned borrow-out (1 when a<b unsigned).
REQ-011 SHALL have port overflow  output  1  signed two's-complement overflow of a-b.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE; IDLE->RUN on accepted start; RUN->DONE after exactly WIDTH RUN cycles; DONE->IDLE unconditionally after one cycle.
REQ-013 SHALL, on accepted start, load a and b into shift registers, clear bit counter to 0 and clear the borrow flip-flop to 0.
REQ-014 SHALL, in each RUN cycle i (0..WIDTH-1), compute bit i via one full-subtractor cell: d = ai XOR bi XOR bin, bout = (~ai & bi) | (~(ai XOR bi) & bin), shifting LSB first.
REQ-015 SHALL register borrow-out of each RUN cycle as borrow-in of the next cycle.
REQ-016 SHALL assert done=1 only in the DONE cycle, i.e. WIDTH+1 rising edges after the edge that accepted start.
REQ-017 SHALL update diff, borrow, overflow on entry to DONE and hold them unchanged until the next DONE.
REQ-018 SHALL compute overflow = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]) using captured operands.
REQ-019 SHALL ignore start (and a, b changes) while in RUN or DONE; no queuing.
REQ-020 SHALL accept a start presented in the IDLE cycle immediately following DONE (back-to-back throughput one result per WIDTH+2 cycles).
REQ-021 SHALL keep ready combinationally equal to (state==IDLE) and done equal to (state==DONE), both glitch-free decodes of registered state.

Reset
REQ-022 SHALL, while rst_n=0, force state=IDLE, counter=0, borrow flip-flop=0, shift registers=0, diff=0, borrow=0, overflow=0; hence ready=1, done=0.
REQ-023 SHALL abandon any in-progress operation on rst_n assertion mid-RUN or mid-DONE, with no done pulse produced for it.
REQ-024 SHALL accept start on the first rising edge after rst_n deasserts.

Structure
REQ-025 SHALL place the state enum (IDLE, RUN, DONE) in shared package arith_pkg.
REQ-026 SHALL instantiate one combinational sub-module full_subtractor (ports a, b, bin, d, bout), verified standalone by exhaustive 8-row truth table.
REQ-027 SHALL size the counter as $clog2(WIDTH)+1 bits; no multipliers or wide adders permitted.

Verification (WIDTH=8)
REQ-028 SHALL check a=5, b=3 -> diff=0x02, borrow=0, overflow=0, done exactly 9 edges after start edge.
REQ-029 SHALL check a=3, b=5 -> diff=0xFE, borrow=1, overflow=0.
REQ-030 SHALL check a=0x80, b=0x01 -> diff=0x7F, borrow=0, overflow=1; and a=0x7F, b=0xFF -> diff=0x80, borrow=1, overflow=1.
REQ-031 SHALL check start re-asserted with a=0xFF, b=0 during RUN of 5-3 -> result still 0x02, single done pulse, ready=0 throughout.
REQ-032 SHALL check rst_n pulsed low at RUN cycle 4 -> no done, all outputs 0, ready=1; subsequent 0-0 -> diff=0, borrow=0.
REQ-033 SHALL check back-to-back starts (10-4 then 4-10) -> diff 0x06 then 0xFA, done pulses exactly 10 edges apart.
